des_key_schedule: RTL and testbench



---
 rtl/des_key_schedule.sv | 178 +++++++++++++++++
 tb/tb_des_key_schedule.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES key schedule generator.
// Loads PC-1 of the key into the C/D halves, then presents one 48-bit
// subkey per valid/ready handshake, rotating C/D between rounds.
// Bit numbering is DES style: bit 1 is the MSB of every vector.
// Optional feature macro: KS_DECRYPT_EN adds the decrypt port and the
// reverse (K16..K1, right-rotating) order.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:64] key_in,
`ifdef KS_DECRYPT_EN
  input  logic        decrypt,
`endif
  output logic [1:48] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // PC-1: key bit feeding each C (first 28) and D (last 28) position.
  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: CD bit feeding each subkey position.
  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state_q, state_d;
  logic [1:28] c_q, c_d;
  logic [1:28] d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        done_q, done_d;
`ifdef KS_DECRYPT_EN
  logic        dec_q, dec_d;
`endif

  logic [1:28] pc1_c, pc1_d;
  logic [1:56] cd;
  logic [1:48] pc2_out;
  logic        last_round;

  // True when DES round (idx0 + 1) uses a single-bit shift (rounds 1, 2, 9, 16).
  function automatic logic shift_is_one(input logic [3:0] idx0);
    return (idx0 == 4'd0) || (idx0 == 4'd1) || (idx0 == 4'd8) || (idx0 == 4'd15);
  endfunction

  function automatic logic [1:28] rotl(input logic [1:28] v, input logic two);
    return two ? {v[3:28], v[1:2]} : {v[2:28], v[1]};
  endfunction

`ifdef KS_DECRYPT_EN
  function automatic logic [1:28] rotr(input logic [1:28] v, input logic two);
    return two ? {v[27:28], v[1:26]} : {v[28], v[1:27]};
  endfunction
`endif

  // Fixed permutations are pure wiring: PC-1 of the key, PC-2 of the halves.
  for (genvar i = 0; i < 28; i++) begin : g_pc1
    assign pc1_c[i+1] = key_in[PC1[i]];
    assign pc1_d[i+1] = key_in[PC1[i+28]];
  end

  assign cd = {c_q, d_q};

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign pc2_out[i+1] = cd[PC2[i]];
  end

`ifdef KS_DECRYPT_EN
  assign last_round = dec_q ? (round_q == 4'd0) : (round_q == 4'd15);
`else
  assign last_round = (round_q == 4'd15);
`endif

  // Next-state logic: load on start, step the rotation on each handshake.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    done_d  = 1'b0;
`ifdef KS_DECRYPT_EN
    dec_d   = dec_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
`ifdef KS_DECRYPT_EN
          dec_d = decrypt;
          if (decrypt) begin
            // Unrotated halves equal the round-16 state (total shift is 28).
            c_d     = pc1_c;
            d_d     = pc1_d;
            round_d = 4'd15;
          end else
`endif
          begin
            c_d     = rotl(pc1_c, 1'b0);
            d_d     = rotl(pc1_d, 1'b0);
            round_d = 4'd0;
          end
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (last_round) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef KS_DECRYPT_EN
            if (dec_q) begin
              // Undo the shift of the round just presented.
              c_d     = rotr(c_q, !shift_is_one(round_q));
              d_d     = rotr(d_q, !shift_is_one(round_q));
              round_d = round_q - 4'd1;
            end else
`endif
            begin
              // Apply the shift of the round about to be presented.
              c_d     = rotl(c_q, !shift_is_one(round_q + 4'd1));
              d_d     = rotl(d_q, !shift_is_one(round_q + 4'd1));
              round_d = round_q + 4'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
`ifdef KS_DECRYPT_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      done_q  <= done_d;
`ifdef KS_DECRYPT_EN
      dec_q   <= dec_d;
`endif
    end
  end

  assign subkey_valid = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign round_idx    = round_q;
  assign done         = done_q;
  assign subkey       = subkey_valid ? pc2_out : '0;

endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: randomized scoreboard bench for des_key_schedule.
// The reference model computes each subkey directly from the DES rules
// (PC-1, cumulative shift count, PC-2); a monitor pops expectations on
// every handshake.
module tb_des_key_schedule;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:64] key_in;
`ifdef KS_DECRYPT_EN
  logic        decrypt;
`endif
  logic [1:48] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .key_in       (key_in),
`ifdef KS_DECRYPT_EN
    .decrypt      (decrypt),
`endif
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    logic [3:0]  idx;
    logic [47:0] key;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          failures;
  int          done_cnt;
  bit          exp_done;
  logic [47:0] got_key [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Subkey of DES round r (1..16): rotate PC-1 halves by the cumulative shift, then PC-2.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int r);
    logic [27:0] cb, db;
    logic [55:0] cdv;
    logic [47:0] k;
    int tot = 0;
    for (int i = 0; i < r; i++) tot += SHIFTS[i];
    for (int j = 0; j < 28; j++) begin
      cb[5'(j)] = key[6'(64 - PC1[j])];
      db[5'(j)] = key[6'(64 - PC1[j+28])];
    end
    for (int j = 0; j < 28; j++) begin
      cdv[6'(55 - j)] = cb[5'((j + tot) % 28)];
      cdv[6'(27 - j)] = db[5'((j + tot) % 28)];
    end
    for (int j = 0; j < 48; j++) k[6'(47 - j)] = cdv[6'(56 - PC2[j])];
    return k;
  endfunction

  // Monitor: pops and compares on each handshake, checks stalls, idle gating and done.
  initial begin : monitor
    bit          prev_stall = 0;
    logic [47:0] prev_key = '0;
    logic [3:0]  prev_idx = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
        exp_done   = 0;
      end else begin
        if (exp_done || done) begin
          check("done_pulse", 64'(done), 64'(exp_done));
          if (exp_done) check("busy_fall_with_done", 64'(busy), 64'd0);
          if (done) done_cnt++;
        end
        exp_done = 0;
        if (prev_stall && subkey_valid) begin
          check("stall_subkey_stable", 64'(subkey), 64'(prev_key));
          check("stall_round_stable", 64'(round_idx), 64'(prev_idx));
        end
        if (!subkey_valid) check("idle_subkey_zero", 64'(subkey), 64'd0);
        if (subkey_valid && subkey_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_handshake actual=round %0d expected=none", round_idx);
          end else begin
            e = sb.pop_front();
            check("subkey", 64'(subkey), 64'(e.key));
            check("round_idx", 64'(round_idx), 64'(e.idx));
            check("busy_while_valid", 64'(busy), 64'd1);
            got_key[round_idx] = subkey;
            if (e.last) exp_done = 1;
          end
        end
        prev_stall = subkey_valid && !subkey_ready;
        prev_key   = subkey;
        prev_idx   = round_idx;
      end
    end
  end

  // Modes: 0 ready=1, 1 random ready, 2 five-cycle stall at round 3,
  // 3 stray start at round 7, 4 reset at round 9.
  task automatic run_sched(input logic [63:0] key, input bit dec, input int mode);
    int cyc   = 0;
    int hold  = 0;
    bit pulse = 0;
    int done0 = done_cnt;
    bit eff_dec = 0;
    exp_t e;
`ifdef KS_DECRYPT_EN
    eff_dec = dec;
    decrypt = dec;
`else
    if (dec) eff_dec = 0;
`endif
    for (int i = 0; i < 16; i++) got_key[i] = '0;
    for (int i = 0; i < 16; i++) begin
      int r = eff_dec ? 16 - i : i + 1;
      e.idx  = 4'(r - 1);
      e.key  = ref_subkey(key, r);
      e.last = (i == 15);
      sb.push_back(e);
    end
    key_in       = key;
    start        = 1'b1;
    subkey_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("first_valid_latency", 64'(subkey_valid), 64'd1);
    check("busy_rise", 64'(busy), 64'd1);
    while (sb.size() > 0 && cyc < 400) begin
      case (mode)
        1: subkey_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (round_idx == 4'd3 && hold < 5) begin
            subkey_ready = 1'b0;
            hold++;
          end else subkey_ready = 1'b1;
        end
        3: begin
          subkey_ready = 1'b1;
          if (round_idx == 4'd7 && !pulse) begin
            start  = 1'b1;
            key_in = ~key;
            pulse  = 1;
          end else start = 1'b0;
        end
        4: begin
          subkey_ready = 1'b1;
          if (round_idx == 4'd9) begin
            rst_n = 1'b0;
            #1;
            check("rst_valid", 64'(subkey_valid), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_subkey", 64'(subkey), 64'd0);
            check("rst_round", 64'(round_idx), 64'd0);
            sb.delete();
            @(posedge clk); #1;
            rst_n = 1'b1;
            break;
          end
        end
        default: subkey_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("schedule_finished_in_time", 64'(cyc < 400), 64'd1);
    if (mode == 4) begin
      repeat (3) @(posedge clk);
      #1;
      check("no_done_after_reset", 64'(done_cnt), 64'(done0));
    end else begin
      while (!done && cyc < 420) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (mode == 0 || mode == 3) check("valid_to_done_cycles", 64'(cyc), 64'd16);
      repeat (2) @(posedge clk);
      #1;
      check("one_done_pulse", 64'(done_cnt), 64'(done0 + 1));
    end
  endtask

  task automatic check_known(input string tag);
    check({tag, "_k1"},  64'(got_key[0]),  64'h1B02EFFC7072);
    check({tag, "_k2"},  64'(got_key[1]),  64'h79AED9DBC9E5);
    check({tag, "_k16"}, 64'(got_key[15]), 64'hCB3D8B0E17F5);
  endtask

  initial begin : stimulus
    checks       = 0;
    failures     = 0;
    done_cnt     = 0;
    exp_done     = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    subkey_ready = 1'b0;
    key_in       = '0;
`ifdef KS_DECRYPT_EN
    decrypt      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(subkey_valid), 64'd0);
    check("reset_subkey", 64'(subkey), 64'd0);
    check("reset_round", 64'(round_idx), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_sched(64'h133457799BBCDFF1, 1'b0, 0);
    check_known("enc");
    run_sched(64'h123456789ABCDEF0, 1'b0, 0);
    check_known("parity");
`ifdef KS_DECRYPT_EN
    run_sched(64'h133457799BBCDFF1, 1'b1, 0);
    check_known("dec");
    run_sched(64'h133457799BBCDFF1, 1'b1, 2);
`endif
    run_sched(64'h133457799BBCDFF1, 1'b0, 2);
    check_known("stall");
    run_sched(64'h133457799BBCDFF1, 1'b0, 3);
    check_known("stray_start");
    run_sched(64'h133457799BBCDFF1, 1'b0, 4);
    run_sched({$urandom, $urandom}, 1'b0, 0);
    for (int n = 0; n < 20; n++) begin
      run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
